pingpong_buffer: RTL and testbench

//  Dual-bank word buffer between the JTAG chain1 logic (pp_* side) and the DMA engine (dma_* side).
//  The chain side fills or drains one bank while the DMA side works on the other.
//  A swap request from chain1 exchanges the banks once the DMA side is idle.

---
 rtl/pingpong_buffer.sv | 158 +++++++++++++++
 tb/tb_pingpong_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_buffer.sv
// ----------------------------------------------------------------------------
// pingpong_buffer
//   Dual-bank word buffer between the JTAG chain1 logic (pp_* side) and the
//   DMA engine (dma_* side). Each side owns one bank at a time. A swap request
//   from the chain side exchanges the banks once the DMA side is idle.
//
// Ports
//   clock            system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   pp_address       chain-side word address
//   pp_writeEnable   chain-side write strobe
//   pp_dataIn        chain-side write data
//   pp_dataOut       chain-side read data, registered (1-cycle latency)
//   pp_switch        one-cycle swap request
//   switch_ready     high while idle, so a new swap request is accepted
//   dma_address      DMA-side word address
//   dma_writeEnable  DMA-side write strobe
//   dma_dataIn       DMA-side write data
//   dma_dataOut      DMA-side read data, registered (1-cycle latency)
//   dma_busy         DMA transfer in progress; holds off a swap
//   bank_select      bank owned by the chain side (DMA owns the other one)
//   swap_done        one-cycle pulse in the cycle after the banks swap
//   swap_count       number of completed swaps, wraps
// ----------------------------------------------------------------------------
module pingpong_buffer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pp_address,
  input  logic                   pp_writeEnable,
  input  logic [DATA_WIDTH-1:0]  pp_dataIn,
  output logic [DATA_WIDTH-1:0]  pp_dataOut,
  input  logic                   pp_switch,
  output logic                   switch_ready,
  input  logic [ADDR_WIDTH-1:0]  dma_address,
  input  logic                   dma_writeEnable,
  input  logic [DATA_WIDTH-1:0]  dma_dataIn,
  output logic [DATA_WIDTH-1:0]  dma_dataOut,
  input  logic                   dma_busy,
  output logic                   bank_select,
  output logic                   swap_done,
  output logic [COUNT_WIDTH-1:0] swap_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DMA = 2'd1,
    SWAP     = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   bank_select_q;
  logic                   swap_done_q;
  logic [COUNT_WIDTH-1:0] swap_count_q;
  logic [DATA_WIDTH-1:0]  pp_dataOut_q;
  logic [DATA_WIDTH-1:0]  dma_dataOut_q;

  logic [DATA_WIDTH-1:0]  bank0_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  bank1_mem [DEPTH];

  // Per-bank write port, steered by ownership in the current cycle. Bank 0
  // belongs to the chain side when bank_select_q is 0, bank 1 otherwise.
  logic                   bank0_we,    bank1_we;
  logic [ADDR_WIDTH-1:0]  bank0_addr,  bank1_addr;
  logic [DATA_WIDTH-1:0]  bank0_wdata, bank1_wdata;

  always_comb begin
    if (bank_select_q) begin
      bank0_we    = dma_writeEnable;
      bank0_addr  = dma_address;
      bank0_wdata = dma_dataIn;
      bank1_we    = pp_writeEnable;
      bank1_addr  = pp_address;
      bank1_wdata = pp_dataIn;
    end else begin
      bank0_we    = pp_writeEnable;
      bank0_addr  = pp_address;
      bank0_wdata = pp_dataIn;
      bank1_we    = dma_writeEnable;
      bank1_addr  = dma_address;
      bank1_wdata = dma_dataIn;
    end
  end

  // NOTE: the RAM arrays sit in their own always_ff with no reset branch;
  // resetting a memory turns it into thousands of flops instead of a RAM.
  always_ff @(posedge clock) begin
    if (bank0_we) bank0_mem[bank0_addr] <= bank0_wdata;
    if (bank1_we) bank1_mem[bank1_addr] <= bank1_wdata;
  end

  // Registered reads. Because the array write above is also non-blocking,
  // a read of the address being written in the same cycle returns the old
  // word.
  // NOTE: sequential state always uses <=, so every always_ff sees the values
  // from before the clock edge regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      pp_dataOut_q  <= '0;
      dma_dataOut_q <= '0;
    end else begin
      pp_dataOut_q  <= bank_select_q ? bank1_mem[pp_address]  : bank0_mem[pp_address];
      dma_dataOut_q <= bank_select_q ? bank0_mem[dma_address] : bank1_mem[dma_address];
    end
  end

  // ---------------------------------------------------------------- FSM
  // State register, together with the bookkeeping that advances on a swap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      bank_select_q <= 1'b0;
      swap_done_q   <= 1'b0;
      swap_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= (state_q == SWAP);
      if (state_q == SWAP) begin
        bank_select_q <= ~bank_select_q;
        swap_count_q  <= swap_count_q + 1'b1;
      end
    end
  end

  // Next-state logic. A request outside IDLE is dropped, not queued.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pp_switch) state_d = dma_busy ? WAIT_DMA : SWAP;
      end
      WAIT_DMA: begin
        if (!dma_busy) state_d = SWAP;
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    switch_ready = (state_q == IDLE);
  end

  assign pp_dataOut  = pp_dataOut_q;
  assign dma_dataOut = dma_dataOut_q;
  assign bank_select = bank_select_q;
  assign swap_done   = swap_done_q;
  assign swap_count  = swap_count_q;

endmodule

// File: tb/tb_pingpong_buffer.sv
// ----------------------------------------------------------------------------
// tb_pingpong_buffer
//   Self-checking bench for pingpong_buffer. A behavioural reference model
//   (two word arrays, an owner bit, a pending-request flag and a scheduled
//   swap) predicts every output after each clock edge. Directed scenarios are
//   followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_pingpong_buffer;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] pp_address, dma_address;
  logic          pp_writeEnable, dma_writeEnable;
  logic [DW-1:0] pp_dataIn, dma_dataIn;
  logic [DW-1:0] pp_dataOut, dma_dataOut;
  logic          pp_switch, switch_ready, dma_busy;
  logic          bank_select, swap_done;
  logic [CW-1:0] swap_count;

  pingpong_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .pp_address      (pp_address),
    .pp_writeEnable  (pp_writeEnable),
    .pp_dataIn       (pp_dataIn),
    .pp_dataOut      (pp_dataOut),
    .pp_switch       (pp_switch),
    .switch_ready    (switch_ready),
    .dma_address     (dma_address),
    .dma_writeEnable (dma_writeEnable),
    .dma_dataIn      (dma_dataIn),
    .dma_dataOut     (dma_dataOut),
    .dma_busy        (dma_busy),
    .bank_select     (bank_select),
    .swap_done       (swap_done),
    .swap_count      (swap_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  logic [DW-1:0] m_mem [2][2**AW];
  bit            m_vld [2][2**AW];
  bit            m_bank;      // bank owned by the chain side
  int            m_swaps;     // completed swaps (unbounded, reduced mod 2**CW)
  bit            m_pend;      // request accepted, waiting for DMA idle
  bit            m_swap_next; // swap happens during the next cycle
  bit            m_done;

  // One clock cycle: predict from the current inputs, clock, then compare.
  task automatic step();
    logic [DW-1:0] exp_pp, exp_dma;
    bit            pp_v, dma_v, done_n;
    if (reset) begin
      m_bank = 0; m_swaps = 0; m_pend = 0; m_swap_next = 0; m_done = 0;
      exp_pp = '0; exp_dma = '0; pp_v = 1; dma_v = 1;
    end else begin
      exp_pp  = m_mem[m_bank][pp_address];   pp_v  = m_vld[m_bank][pp_address];
      exp_dma = m_mem[!m_bank][dma_address]; dma_v = m_vld[!m_bank][dma_address];
      if (pp_writeEnable) begin
        m_mem[m_bank][pp_address] = pp_dataIn;  m_vld[m_bank][pp_address] = 1;
      end
      if (dma_writeEnable) begin
        m_mem[!m_bank][dma_address] = dma_dataIn; m_vld[!m_bank][dma_address] = 1;
      end
      done_n = m_swap_next;
      if (m_swap_next) begin
        m_bank = !m_bank; m_swaps++; m_swap_next = 0;
      end else if (m_pend) begin
        if (!dma_busy) begin m_pend = 0; m_swap_next = 1; end
      end else if (pp_switch) begin
        if (dma_busy) m_pend = 1; else m_swap_next = 1;
      end
      m_done = done_n;
    end
    @(posedge clock);
    #1;
    if (pp_v)  check("pp_dataOut",  pp_dataOut,  exp_pp);
    if (dma_v) check("dma_dataOut", dma_dataOut, exp_dma);
    check("bank_select",  bank_select,  m_bank);
    check("swap_count",   swap_count,   64'(m_swaps % (2**CW)));
    check("swap_done",    swap_done,    m_done);
    check("switch_ready", switch_ready, !(m_pend || m_swap_next));
  endtask

  task automatic idle_inputs();
    pp_writeEnable = 0; dma_writeEnable = 0; pp_switch = 0;
    pp_address = '0; dma_address = '0; pp_dataIn = '0; dma_dataIn = '0;
  endtask

  initial begin
    reset = 1; dma_busy = 0;
    idle_inputs();
    step(); step();
    check("reset_ready", switch_ready, 1'b1);
    reset = 0;

    // 1: chain write then read; DMA bank holds a different word at addr 3.
    pp_address = 3; pp_writeEnable = 1; pp_dataIn = 32'hA5A5_0001;
    dma_address = 3; dma_writeEnable = 1; dma_dataIn = 32'h0;
    step();
    idle_inputs(); pp_address = 3; dma_address = 3;
    step();
    check("t1_pp_read", pp_dataOut, 32'hA5A5_0001);
    check("t1_dma_differs", dma_dataOut != 32'hA5A5_0001, 1'b1);

    // 2: immediate swap.
    pp_switch = 1; step();
    check("t2_ready_low", switch_ready, 1'b0);
    pp_switch = 0; step();
    check("t2_bank", bank_select, 1'b1);
    check("t2_done", swap_done, 1'b1);
    check("t2_count", swap_count, 8'd1);
    step();
    check("t2_dma_read", dma_dataOut, 32'hA5A5_0001);

    // 3: swap held off by dma_busy; a second request during the wait is dropped.
    dma_busy = 1; step();
    pp_switch = 1; step();
    pp_switch = 0;
    for (int i = 0; i < 10; i++) begin
      pp_switch = (i == 4);
      step();
      check("t3_bank_held", bank_select, 1'b1);
    end
    pp_switch = 0; dma_busy = 0; step();   // SWAP cycle
    step();
    check("t3_swapped", bank_select, 1'b0);
    check("t3_count", swap_count, 8'd2);
    for (int i = 0; i < 4; i++) step();
    check("t3_count_once", swap_count, 8'd2);

    // 4: chain writes in the SWAP cycle go to the old bank, seen later by DMA.
    pp_switch = 1; step();
    pp_switch = 0; pp_address = 9'h1FF; pp_writeEnable = 1; pp_dataIn = 32'hDEAD_01FF;
    step();
    idle_inputs(); dma_address = 9'h1FF; step();
    step();
    check("t4_dma_1ff", dma_dataOut, 32'hDEAD_01FF);
    pp_switch = 1; step();
    pp_switch = 0; pp_address = 9'h000; pp_writeEnable = 1; pp_dataIn = 32'hBEEF_0000;
    step();
    idle_inputs(); dma_address = 9'h000; step();
    step();
    check("t4_dma_000", dma_dataOut, 32'hBEEF_0000);

    // 5: 256 swaps from reset wrap the counter back to 0 with bank 0.
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 256; i++) begin
      pp_switch = 1; step();
      pp_switch = 0; step(); step();
    end
    check("t5_count_wrap", swap_count, 8'd0);
    check("t5_bank", bank_select, 1'b0);

    // 6: reset while waiting for DMA abandons the swap.
    pp_switch = 1; step(); pp_switch = 0; step(); step();
    dma_busy = 1; pp_switch = 1; step(); pp_switch = 0; step();
    check("t6_waiting", switch_ready, 1'b0);
    reset = 1; step();
    check("t6_ready", switch_ready, 1'b1);
    check("t6_bank", bank_select, 1'b0);
    check("t6_count", swap_count, 8'd0);
    reset = 0; dma_busy = 0; step();
    check("t6_no_done", swap_done, 1'b0);
    step();
    check("t6_no_swap", bank_select, 1'b0);

    // Randomized traffic on a small address window so reads hit written words.
    for (int i = 0; i < 3000; i++) begin
      pp_address      = AW'($urandom_range(0, 15));
      dma_address     = AW'($urandom_range(0, 15));
      pp_writeEnable  = $urandom_range(0, 1) == 1;
      dma_writeEnable = $urandom_range(0, 1) == 1;
      pp_dataIn       = $urandom;
      dma_dataIn      = $urandom;
      pp_switch       = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 5) == 0) dma_busy = !dma_busy;
      reset           = $urandom_range(0, 499) == 0;
      if (reset) begin pp_writeEnable = 0; dma_writeEnable = 0; end
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
